// File: rtl/updown_count_sched.sv
// Round-robin scheduler that lends one shared up/down counter to requesters A and B,
// running it toward each job's target and reporting completion or timeout.
module updown_count_sched #(
  parameter int WIDTH   = 3,
  parameter int TIMEOUT = (1 << WIDTH) + 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             req_a_i,
  input  logic             dir_a_i,
  input  logic [WIDTH-1:0] tgt_a_i,
  input  logic             req_b_i,
  input  logic             dir_b_i,
  input  logic [WIDTH-1:0] tgt_b_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             m_o,
  output logic             cnt_en_o,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic             done_a_o,
  output logic             done_b_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_e;

  state_e           state_q;
  logic             dir_q;
  logic [WIDTH-1:0] tgt_q;
  logic             owner_q;
  logic             last_b_q;
  logic [CW-1:0]    cyc_q;
  logic             gnt_a_q, gnt_b_q, done_a_q, done_b_q, err_q, busy_q;

  logic             pick_b_d;
  logic             at_tgt;

  // On a tie the requester that was not served last wins; last_b_q resets to 1 so A goes first.
  always_comb begin
    pick_b_d = req_b_i;
    if (req_a_i && req_b_i) pick_b_d = ~last_b_q;
  end

  assign at_tgt   = (q_i == tgt_q);
  assign m_o      = (state_q != IDLE) & dir_q;
  assign cnt_en_o = (state_q == RUN) & ~at_tgt;

  assign gnt_a_o  = gnt_a_q;
  assign gnt_b_o  = gnt_b_q;
  assign done_a_o = done_a_q;
  assign done_b_o = done_b_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;

  always_ff @(posedge clk_i or negedge clr_i) begin
    if (!clr_i) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      tgt_q    <= '0;
      owner_q  <= 1'b0;
      last_b_q <= 1'b1;
      cyc_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_a_i || req_b_i) begin
            owner_q <= pick_b_d;
            dir_q   <= pick_b_d ? dir_b_i : dir_a_i;
            tgt_q   <= pick_b_d ? tgt_b_i : tgt_a_i;
            gnt_a_q <= ~pick_b_d;
            gnt_b_q <= pick_b_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          cyc_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // The counter runs for at most TIMEOUT enabled cycles before the job is aborted.
          if (at_tgt) begin
            done_a_q <= ~owner_q;
            done_b_q <= owner_q;
            err_q    <= 1'b0;
            state_q  <= DONE;
          end else if (cyc_q == CW'(TIMEOUT - 1)) begin
            done_a_q <= ~owner_q;
            done_b_q <= owner_q;
            err_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        DONE: begin
          last_b_q <= owner_q;
          err_q    <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_count_sched.sv
// Self-checking bench: a behavioural counter plus a job-level model (round-robin winner,
// modular step count, timeout) checked against updown_count_sched.
module tb_updown_count_sched;

  localparam int W  = 3;
  localparam int TO = (1 << W) + 2;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         reqA = 1'b0, dirA = 1'b0, reqB = 1'b0, dirB = 1'b0;
  logic [W-1:0] tgtA = '0, tgtB = '0;
  logic [W-1:0] q;
  logic         m, cntEn, gntA, gntB, doneA, doneB, err, busy;

  logic         freeze = 1'b0;
  logic         loadEn = 1'b0;
  logic [W-1:0] loadVal = '0;

  int passCnt = 0;
  int totalCnt = 0;
  bit lastB = 1'b1;

  updown_count_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .clr_i(clr),
    .req_a_i(reqA), .dir_a_i(dirA), .tgt_a_i(tgtA),
    .req_b_i(reqB), .dir_b_i(dirB), .tgt_b_i(tgtB),
    .q_i(q),
    .m_o(m), .cnt_en_o(cntEn),
    .gnt_a_o(gntA), .gnt_b_o(gntB),
    .done_a_o(doneA), .done_b_o(doneB),
    .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared counter: wraps modulo 2^W, can be frozen or preloaded.
  always @(posedge clk) begin
    if (loadEn) q <= loadVal;
    else if (cntEn && !freeze) q <= m ? q - 3'd1 : q + 3'd1;
  end

  function automatic int stepsFor(input bit down, input int from, input int to);
    int d;
    d = down ? (from - to) : (to - from);
    return ((d % (1 << W)) + (1 << W)) % (1 << W);
  endfunction

  task automatic setQ(input logic [W-1:0] v);
    @(negedge clk);
    loadVal = v;
    loadEn  = 1'b1;
    @(negedge clk);
    loadEn  = 1'b0;
  endtask

  // Observes one job from grant to done; collects what happened without judging it.
  task automatic runJob(input bit drop, input bit scramble,
                        output int gntWho, output int doneWho, output int enCnt,
                        output int mDown, output int errSeen, output int gntAt,
                        output int doneAt, output int busyLow);
    gntWho = 0; doneWho = 0; enCnt = 0; mDown = 0; errSeen = 0;
    gntAt = -1; doneAt = -1; busyLow = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gntWho == 0 && (gntA || gntB)) begin
        gntWho = gntA ? 1 : 2;
        gntAt  = i;
      end
      if (gntWho != 0 && !busy) busyLow++;
      if (gntWho != 0 && scramble) begin
        dirA = 1'($urandom); tgtA = W'($urandom);
        dirB = 1'($urandom); tgtB = W'($urandom);
      end
      if (cntEn) begin
        enCnt++;
        if (m) mDown++;
      end
      if (doneA || doneB) begin
        doneWho = doneA ? 1 : 2;
        errSeen = int'(err);
        doneAt  = i;
        if (drop) begin
          reqA = 1'b0;
          reqB = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    lastB = 1'b1;
  endtask

  task automatic test_reset();
    clr  = 1'b0;
    reqA = 1'b1;
    repeat (3) @(negedge clk);
    totalCnt++;
    if ({m, cntEn, gntA, gntB, doneA, doneB, err, busy} !== 8'h00)
      $display("[TB] FAIL reset_outputs: got %b expected 00000000",
               {m, cntEn, gntA, gntB, doneA, doneB, err, busy});
    else passCnt++;
    reqA = 1'b0;
    clr  = 1'b1;
    lastB = 1'b1;
  endtask

  task automatic test_basic();
    int g, d, e, md, er, ga, da, bl;
    setQ(3'd0);
    reqA = 1'b1; dirA = 1'b0; tgtA = 3'd5;
    runJob(1'b1, 1'b0, g, d, e, md, er, ga, da, bl);
    totalCnt++; if (g !== 1) $display("[TB] FAIL basic_gnt: got %0d expected 1", g); else passCnt++;
    totalCnt++; if (e !== 5) $display("[TB] FAIL basic_steps: got %0d expected 5", e); else passCnt++;
    totalCnt++; if (md !== 0) $display("[TB] FAIL basic_mode: got %0d down cycles expected 0", md); else passCnt++;
    totalCnt++; if (d !== 1 || er !== 0) $display("[TB] FAIL basic_done: got who=%0d err=%0d expected who=1 err=0", d, er); else passCnt++;
    totalCnt++; if (da - ga !== 7) $display("[TB] FAIL basic_latency: got %0d expected 7", da - ga); else passCnt++;
    totalCnt++; if (bl !== 0) $display("[TB] FAIL basic_busy: got %0d idle cycles expected 0", bl); else passCnt++;
    totalCnt++; if (q !== 3'd5) $display("[TB] FAIL basic_q: got %0d expected 5", q); else passCnt++;
    lastB = 1'b0;
  endtask

  task automatic test_wrap();
    int g, d, e, md, er, ga, da, bl;
    setQ(3'd6);
    reqB = 1'b1; dirB = 1'b0; tgtB = 3'd1;
    runJob(1'b1, 1'b0, g, d, e, md, er, ga, da, bl);
    totalCnt++; if (g !== 2) $display("[TB] FAIL wrap_gnt: got %0d expected 2", g); else passCnt++;
    totalCnt++; if (e !== 3) $display("[TB] FAIL wrap_steps: got %0d expected 3", e); else passCnt++;
    totalCnt++; if (d !== 2 || er !== 0) $display("[TB] FAIL wrap_done: got who=%0d err=%0d expected who=2 err=0", d, er); else passCnt++;
    totalCnt++; if (q !== 3'd1) $display("[TB] FAIL wrap_q: got %0d expected 1", q); else passCnt++;
    lastB = 1'b1;
  endtask

  task automatic test_round_robin();
    int g, d, e, md, er, ga, da, bl;
    int expWho[3] = '{1, 2, 1};
    int expDown[3] = '{0, 2, 0};
    pulseReset();
    setQ(3'd0);
    dirA = 1'b0; tgtA = 3'd2; dirB = 1'b1; tgtB = 3'd0;
    reqA = 1'b1; reqB = 1'b1;
    for (int j = 0; j < 3; j++) begin
      runJob(j == 2, 1'b0, g, d, e, md, er, ga, da, bl);
      totalCnt++;
      if (g !== expWho[j] || d !== expWho[j])
        $display("[TB] FAIL rr_order%0d: got gnt=%0d done=%0d expected %0d", j, g, d, expWho[j]);
      else passCnt++;
      totalCnt++;
      if (e !== 2 || md !== expDown[j])
        $display("[TB] FAIL rr_steps%0d: got %0d (down %0d) expected 2 (down %0d)", j, e, md, expDown[j]);
      else passCnt++;
    end
    lastB = 1'b0;
  endtask

  task automatic test_zero_step();
    int g, d, e, md, er, ga, da, bl;
    setQ(3'd4);
    reqA = 1'b1; dirA = 1'b1; tgtA = 3'd4;
    runJob(1'b1, 1'b0, g, d, e, md, er, ga, da, bl);
    totalCnt++; if (g !== 1) $display("[TB] FAIL zero_gnt: got %0d expected 1", g); else passCnt++;
    totalCnt++; if (e !== 0) $display("[TB] FAIL zero_steps: got %0d expected 0", e); else passCnt++;
    totalCnt++; if (d !== 1 || er !== 0) $display("[TB] FAIL zero_done: got who=%0d err=%0d expected who=1 err=0", d, er); else passCnt++;
    totalCnt++; if (da - ga !== 2) $display("[TB] FAIL zero_latency: got %0d expected 2", da - ga); else passCnt++;
    lastB = 1'b0;
  endtask

  task automatic test_timeout();
    int g, d, e, md, er, ga, da, bl;
    freeze = 1'b1;
    setQ(3'd2);
    reqA = 1'b1; dirA = 1'b0; tgtA = 3'd3;
    runJob(1'b1, 1'b0, g, d, e, md, er, ga, da, bl);
    totalCnt++; if (e !== TO) $display("[TB] FAIL timeout_cycles: got %0d expected %0d", e, TO); else passCnt++;
    totalCnt++; if (d !== 1 || er !== 1) $display("[TB] FAIL timeout_done: got who=%0d err=%0d expected who=1 err=1", d, er); else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (cntEn !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("[TB] FAIL timeout_after: got cnt_en=%b busy=%b err=%b expected 0 0 0", cntEn, busy, err);
    else passCnt++;
    freeze = 1'b0;
    lastB = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int g, d, e, md, er, ga, da, bl, doneSeen, exp;
    bit sawRun;
    setQ(3'd3);
    reqA = 1'b1; dirA = 1'b0; tgtA = 3'd6;
    sawRun = 1'b0;
    for (int i = 0; i < 20 && !sawRun; i++) begin
      @(negedge clk);
      if (cntEn) sawRun = 1'b1;
    end
    totalCnt++; if (!sawRun) $display("[TB] FAIL midrst_run: got no cnt_en expected cnt_en"); else passCnt++;
    #2 clr = 1'b0;
    #1;
    totalCnt++;
    if ({m, cntEn, gntA, gntB, doneA, doneB, err, busy} !== 8'h00)
      $display("[TB] FAIL midrst_outputs: got %b expected 00000000",
               {m, cntEn, gntA, gntB, doneA, doneB, err, busy});
    else passCnt++;
    reqA = 1'b0;
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (doneA || doneB) doneSeen++;
    end
    clr = 1'b1;
    lastB = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (doneA || doneB) doneSeen++;
    end
    totalCnt++; if (doneSeen !== 0) $display("[TB] FAIL midrst_nodone: got %0d done pulses expected 0", doneSeen); else passCnt++;
    exp = stepsFor(1'b1, int'(q), 0);
    reqB = 1'b1; dirB = 1'b1; tgtB = 3'd0;
    runJob(1'b1, 1'b0, g, d, e, md, er, ga, da, bl);
    totalCnt++; if (g !== 2 || d !== 2 || er !== 0) $display("[TB] FAIL midrst_next: got gnt=%0d done=%0d err=%0d expected 2 2 0", g, d, er); else passCnt++;
    totalCnt++; if (e !== exp || q !== 3'd0) $display("[TB] FAIL midrst_steps: got %0d q=%0d expected %0d q=0", e, q, exp); else passCnt++;
    lastB = 1'b1;
  endtask

  task automatic test_random();
    int g, d, e, md, er, ga, da, bl;
    int mode, expWho, steps;
    bit winB, eDir;
    logic [W-1:0] q0, eTgt;
    for (int n = 0; n < 24; n++) begin
      q0 = W'($urandom);
      setQ(q0);
      mode = $urandom_range(0, 2);
      dirA = 1'($urandom); tgtA = W'($urandom);
      dirB = 1'($urandom); tgtB = W'($urandom);
      winB = (mode == 2) ? !lastB : (mode == 1);
      eDir = winB ? dirB : dirA;
      eTgt = winB ? tgtB : tgtA;
      expWho = winB ? 2 : 1;
      steps = stepsFor(eDir, int'(q0), int'(eTgt));
      reqA = (mode != 1);
      reqB = (mode != 0);
      runJob(1'b1, 1'b1, g, d, e, md, er, ga, da, bl);
      totalCnt++;
      if (g !== expWho || d !== expWho || er !== 0)
        $display("[TB] FAIL rand%0d_who: got gnt=%0d done=%0d err=%0d expected %0d %0d 0", n, g, d, er, expWho, expWho);
      else passCnt++;
      totalCnt++;
      if (e !== steps || md !== (eDir ? steps : 0) || q !== eTgt)
        $display("[TB] FAIL rand%0d_steps: got %0d (down %0d) q=%0d expected %0d dir=%0d q=%0d", n, e, md, q, steps, eDir, eTgt);
      else passCnt++;
      lastB = winB;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_zero_step();
    test_timeout();
    test_reset_mid_run();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
